div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle sequencer for the MIPS DIV/DIVU instructions in the execute stage. It latches operands when the decoded divide reaches E, runs a 32-iteration restoring shift-subtract divide, and holds the pipeline through a stall request until the 64-bit {HI,LO} result is ready. It sits between the E-stage ALU operand muxes and the HI/LO write path, and its stall output feeds the hazard unit that drives `stallE` and the stalls of earlier stages.

## Interface
Parameters:
- `WIDTH`, 32: operand width; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  divide instruction valid in E; held high while E is stalled.
- `signed_div`  in  1  1 = DIV, 0 = DIVU; sampled with `start`.
- `annul`  in  1  flush or exception kill of the E-stage instruction.
- `opa`  in  WIDTH  dividend (rs).
- `opb`  in  WIDTH  divisor (rt).
- `stall_div`  out  1  stall request to the hazard unit.
- `ready`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  2*WIDTH  {HI = remainder, LO = quotient}.

## Operation
- States: IDLE, BUSY, ZERO, DONE.
- IDLE:
  - `start & ~annul & opb!=0`: latch |opa|, |opb|, quotient sign (opa[31]^opb[31])&signed_div, remainder sign opa[31]&signed_div. Clear counter. Go to BUSY.
  - `start & ~annul & opb==0`: go to ZERO.
- BUSY: one iteration per cycle on a 33-bit partial remainder.
  - Shift {rem, dividend} left by 1 and trial-subtract the divisor.
  - If the trial result is non-negative, keep it and set the quotient bit; otherwise restore.
  - The counter increments 0..31. After iteration 31 completes, go to DONE.
- ZERO: load `result` = {opa, 32'hFFFF_FFFF} unconditionally, regardless of signedness. Go to DONE.
- DONE:
  - Assert `ready`. `result` holds the sign-corrected values: negate the quotient if the quotient sign is set, and negate the remainder if the remainder sign is set.
  - Always return to IDLE next cycle.
- Signed corner case: -2^31 / -1 gives LO = 32'h8000_0000 (wraps) and HI = 0. No trap is raised.
- `annul`:
  - In any state, forces IDLE on the next edge.
  - `ready` is never pulsed for the killed operation.
  - `result` keeps its previous value.
  - Has priority over `start` in the same cycle.
- Operand or `signed_div` changes after the latch cycle are ignored.
- `stall_div` (combinational) = ~annul & ((IDLE & start) | BUSY | ZERO). It is 0 in DONE.
- `result` is a register. It changes only in the cycle entering DONE and holds until the next completed operation, so the HI/LO write in M can read it after E advances.
- Back-to-back divides: `start` high in the IDLE cycle right after DONE begins a new operation. This is legal because the pipeline advanced during DONE.

## Timing
- `start` is first seen in IDLE at cycle T:
  - BUSY occupies T+1..T+32.
  - DONE is at T+33, and `ready` = 1 at T+33.
  - `stall_div` is high T..T+32 (33 cycles) and low at T+33, so E advances on the T+33 edge.
- Divide-by-zero: ZERO at T+1, DONE at T+2, `stall_div` high T..T+1.
- Reset values: state IDLE, counter 0, `result` 0, `ready` 0. `stall_div` is 0 while `start` = 0.
- Reset asserted mid-operation aborts immediately (asynchronous). No `ready` follows release.
- `annul` at cycle A: `stall_div` drops in cycle A itself, and the state is IDLE at A+1.

## Test plan
- DIVU 100 / 7, `start` at T: `stall_div` high T..T+32; at T+33 `ready` = 1, `result` = {32'd2, 32'd14}.
- DIV -7 / 2 (32'hFFFF_FFF9 / 2): `result` = {32'hFFFF_FFFF, 32'hFFFF_FFFD}. DIV 7 / -2: {32'd1, 32'hFFFF_FFFD}.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: `result` = {32'h0, 32'h8000_0000}, latency 33.
- DIVU 5 / 0: ZERO at T+1, `ready` at T+2, `result` = {32'd5, 32'hFFFF_FFFF}.
- Annul at T+10 mid-BUSY: `stall_div` 0 at T+10, IDLE at T+11, `ready` never pulses, `result` unchanged. Repeat with `rst` low at T+10: all outputs read reset values immediately.
- Back-to-back DIVU 9/3 then 10/4 with `start` held high: first `ready` at T+33 with {0, 3}; second starts at T+34 and gives `ready` at T+67 with {2, 2}.

Source files
------------

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle DIV/DIVU sequencer for the execute stage.
// Latches operands when a divide reaches E, runs a restoring shift-subtract
// divide (one quotient bit per cycle), and holds the pipeline via stall_div
// until the {HI = remainder, LO = quotient} result register is loaded.
module div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic               stall_div,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ZERO = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   rem_q,    rem_d;
  logic [WIDTH-1:0]   quo_q,    quo_d;
  logic [WIDTH-1:0]   dvs_q,    dvs_d;
  logic               qneg_q,   qneg_d;
  logic               rneg_q,   rneg_d;
  logic               ready_q,  ready_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   opa_abs;
  logic [WIDTH-1:0]   opb_abs;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   quo_fix;

  // Operand magnitudes; -2^(WIDTH-1) maps to itself, which is the correct unsigned magnitude.
  always_comb begin
    opa_abs = (signed_div && opa[WIDTH-1]) ? (~opa + WIDTH'(1)) : opa;
    opb_abs = (signed_div && opb[WIDTH-1]) ? (~opb + WIDTH'(1)) : opb;
  end

  // One restoring iteration: shift {rem, dividend} left, trial-subtract, keep or restore.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvs_q};
    rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    rem_fix  = rneg_q ? (~rem_next + WIDTH'(1)) : rem_next;
    quo_fix  = qneg_q ? (~quo_next + WIDTH'(1)) : quo_next;
  end

  // Next-state and datapath control; annul overrides everything and leaves result intact.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    ready_d  = 1'b0;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (opb == '0) begin
            // Raw dividend is kept for the divide-by-zero result.
            quo_d   = opa;
            state_d = S_ZERO;
          end else begin
            rem_d   = '0;
            quo_d   = opa_abs;
            dvs_d   = opb_abs;
            qneg_d  = (opa[WIDTH-1] ^ opb[WIDTH-1]) & signed_div;
            rneg_d  = opa[WIDTH-1] & signed_div;
            cnt_d   = '0;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_ZERO: begin
        result_d = {quo_q, {WIDTH{1'b1}}};
        ready_d  = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (annul) begin
      state_d  = S_IDLE;
      ready_d  = 1'b0;
      result_d = result_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  // Stall request is combinational so the hazard unit sees it in the cycle start arrives.
  always_comb begin
    stall_div = ~annul & (((state_q == S_IDLE) & start) |
                          (state_q == S_BUSY) |
                          (state_q == S_ZERO));
  end

  assign ready  = ready_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed spec vectors plus random
// operands against an arithmetic reference model.
module tb_div_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        stall_div;
  logic        ready;
  logic [63:0] result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [63:0] last_res = 64'h0;

  div_sequencer #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .opa        (opa),
    .opb        (opb),
    .stall_div  (stall_div),
    .ready      (ready),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: MIPS semantics via host arithmetic (truncating division).
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issues one divide at cycle T (start held while stalled), scrambles operands after the latch.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int t0, output int lat, output int stalls, output logic [63:0] res);
    opa = a; opb = b; signed_div = s; start = 1'b1;
    t0 = cyc; lat = -1; stalls = 0; res = 64'hx;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (stall_div) stalls++;
      if (ready) begin
        lat = k;
        res = result;
        break;
      end
      @(posedge clk); #1;
      opa = $urandom; opb = $urandom; signed_div = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; opa = '0; opb = '0;
    repeat (2) @(negedge clk);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
    total++; if (result !== 64'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
    total++; if (stall_div !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_div); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++; if (stall_div !== 1'b0) begin bad++; $display("FAIL idle_stall got=%b exp=0", stall_div); end
    @(posedge clk); #1;
  endtask

  task automatic test_divu_basic;
    int t0, lat, st; logic [63:0] r;
    do_div(32'd100, 32'd7, 1'b0, t0, lat, st, r);
    total++; if (lat !== 33) begin bad++; $display("FAIL divu_latency got=%0d exp=33", lat); end
    total++; if (st !== 33) begin bad++; $display("FAIL divu_stall_cycles got=%0d exp=33", st); end
    total++; if (r !== {32'd2, 32'd14}) begin bad++; $display("FAIL divu_100_7 got=%h exp=%h", r, {32'd2, 32'd14}); end
    @(negedge clk);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL ready_pulse_width got=%b exp=0", ready); end
    total++; if (result !== {32'd2, 32'd14}) begin bad++; $display("FAIL result_hold got=%h exp=%h", result, {32'd2, 32'd14}); end
    last_res = {32'd2, 32'd14};
    @(posedge clk); #1;
  endtask

  task automatic test_signed;
    int t0, lat, st; logic [63:0] r;
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, t0, lat, st, r);
    total++; if (r !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin bad++; $display("FAIL div_m7_2 got=%h exp=%h", r, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); end
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, t0, lat, st, r);
    total++; if (r !== {32'd1, 32'hFFFF_FFFD}) begin bad++; $display("FAIL div_7_m2 got=%h exp=%h", r, {32'd1, 32'hFFFF_FFFD}); end
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, t0, lat, st, r);
    total++; if (r !== {32'h0, 32'h8000_0000}) begin bad++; $display("FAIL div_min_m1 got=%h exp=%h", r, {32'h0, 32'h8000_0000}); end
    total++; if (lat !== 33) begin bad++; $display("FAIL div_min_m1_latency got=%0d exp=33", lat); end
    last_res = r;
  endtask

  task automatic test_div_zero;
    int t0, lat, st; logic [63:0] r;
    do_div(32'd5, 32'd0, 1'b0, t0, lat, st, r);
    total++; if (lat !== 2) begin bad++; $display("FAIL divzero_latency got=%0d exp=2", lat); end
    total++; if (st !== 2) begin bad++; $display("FAIL divzero_stall_cycles got=%0d exp=2", st); end
    total++; if (r !== {32'd5, 32'hFFFF_FFFF}) begin bad++; $display("FAIL divzero_5 got=%h exp=%h", r, {32'd5, 32'hFFFF_FFFF}); end
    do_div(32'hFFFF_FFFB, 32'd0, 1'b1, t0, lat, st, r);
    total++; if (r !== {32'hFFFF_FFFB, 32'hFFFF_FFFF}) begin bad++; $display("FAIL divzero_signed got=%h exp=%h", r, {32'hFFFF_FFFB, 32'hFFFF_FFFF}); end
    last_res = r;
  endtask

  task automatic test_annul;
    int rdy;
    opa = 32'd1000; opb = 32'd3; signed_div = 1'b0; start = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    annul = 1'b1;
    @(negedge clk);
    total++; if (stall_div !== 1'b0) begin bad++; $display("FAIL annul_stall_same_cycle got=%b exp=0", stall_div); end
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0;
    @(negedge clk);
    total++; if (stall_div !== 1'b0) begin bad++; $display("FAIL annul_idle_next got=%b exp=0", stall_div); end
    // start and annul together: annul wins, nothing is launched.
    @(posedge clk); #1;
    start = 1'b1; annul = 1'b1; opb = 32'd0;
    @(negedge clk);
    total++; if (stall_div !== 1'b0) begin bad++; $display("FAIL annul_vs_start_stall got=%b exp=0", stall_div); end
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    rdy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) rdy++;
    end
    total++; if (rdy !== 0) begin bad++; $display("FAIL annul_no_ready got=%0d exp=0", rdy); end
    total++; if (result !== last_res) begin bad++; $display("FAIL annul_result_kept got=%h exp=%h", result, last_res); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int rdy;
    opa = 32'd77; opb = 32'd5; signed_div = 1'b0; start = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b0; start = 1'b0;
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0", ready); end
    total++; if (result !== 64'h0) begin bad++; $display("FAIL midrst_result got=%h exp=0", result); end
    total++; if (stall_div !== 1'b0) begin bad++; $display("FAIL midrst_stall got=%b exp=0", stall_div); end
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    rdy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) rdy++;
    end
    total++; if (rdy !== 0) begin bad++; $display("FAIL midrst_no_ready got=%0d exp=0", rdy); end
    last_res = 64'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int t1, l1, s1, t2, l2, s2; logic [63:0] r1, r2;
    do_div(32'd9, 32'd3, 1'b0, t1, l1, s1, r1);
    do_div(32'd10, 32'd4, 1'b0, t2, l2, s2, r2);
    total++; if (l1 !== 33) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=33", l1); end
    total++; if (r1 !== {32'd0, 32'd3}) begin bad++; $display("FAIL b2b_first got=%h exp=%h", r1, {32'd0, 32'd3}); end
    total++; if (t2 - t1 !== 34) begin bad++; $display("FAIL b2b_second_start got=%0d exp=34", t2 - t1); end
    total++; if (t2 + l2 - t1 !== 67) begin bad++; $display("FAIL b2b_second_ready got=%0d exp=67", t2 + l2 - t1); end
    total++; if (r2 !== {32'd2, 32'd2}) begin bad++; $display("FAIL b2b_second got=%h exp=%h", r2, {32'd2, 32'd2}); end
    last_res = r2;
  endtask

  task automatic test_random;
    int t0, lat, st, gap, sel, exp_lat;
    logic [31:0] a, b; logic s; logic [63:0] r, e;
    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      e = model(a, b, s);
      exp_lat = (b == 32'h0) ? 2 : 33;
      do_div(a, b, s, t0, lat, st, r);
      total++; if (r !== e) begin bad++; $display("FAIL rand_result a=%h b=%h s=%b got=%h exp=%h", a, b, s, r, e); end
      total++; if (lat !== exp_lat) begin bad++; $display("FAIL rand_latency got=%0d exp=%0d", lat, exp_lat); end
      last_res = e;
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    test_reset;
    test_divu_basic;
    test_signed;
    test_div_zero;
    test_annul;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
